// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: single-bit SPI mode-0 flash READ sequencer with word streaming.
// Define SPI_FLASH_FAST_READ_EN for FAST READ (0x0B plus DUMMY_CYC dummy clocks).
module spi_flash_rd_seq #(
  parameter int DW        = 32,
  parameter int CLK_DIV   = 1,
  parameter int DUMMY_CYC = 8,
  parameter int CS_GAP    = 4
) (
  input  logic          spi_flash_aclk,
  input  logic          spi_flash_areset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [23:0]   req_addr,
  input  logic [7:0]    req_len,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic          dout_last,
  output logic          spi_csn_o,
  output logic          spi_sck,
  output logic          spi_sdo_o,
  output logic          spi_sdo_en,
  input  logic          spi_sdi_i,
  output logic          busy
);
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam bit USE_DUMMY = DUMMY_CYC > 0;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam bit USE_DUMMY = 1'b0;
`endif
  localparam int DVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW  = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, DATA, HOLD, GAP
  } st_t;

  st_t st_q, st_d;
  logic req_ready_q, req_ready_d;
  logic busy_q, busy_d;
  logic csn_q, csn_d;
  logic sck_q, sck_d;
  logic sdo_q, sdo_d;
  logic sdo_en_q, sdo_en_d;
  logic [31:0] mo_q, mo_d;
  logic [DW-1:0] asm_q, asm_d;
  logic [DW-1:0] dd_q, dd_d;
  logic dv_q, dv_d;
  logic dl_q, dl_d;
  logic [DVW-1:0] div_q, div_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic [8:0] wcnt_q, wcnt_d;
  logic [7:0] len_q, len_d;
  logic [GW-1:0] gap_q, gap_d;
  logic tick, lst, free, ld;

  assign tick = div_q == DVW'(CLK_DIV - 1);
  assign lst  = wcnt_q == {1'b0, len_q};
  assign free = !dv_q || dout_ready;

  always_comb begin
    st_d        = st_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    csn_d       = csn_q;
    sck_d       = sck_q;
    sdo_d       = sdo_q;
    sdo_en_d    = sdo_en_q;
    mo_d        = mo_q;
    asm_d       = asm_q;
    dd_d        = dd_q;
    dv_d        = dv_q;
    dl_d        = dl_q;
    div_d       = div_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    gap_d       = gap_q;
    ld          = 1'b0;
    if (dv_q && dout_ready) begin
      dv_d = 1'b0;
      dl_d = 1'b0;
    end
    unique case (st_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          mo_d        = {OPC, req_addr};
          len_d       = req_len;
          wcnt_d      = '0;
          st_d        = CMD;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (st_q == CMD && csn_q) begin
          csn_d    = 1'b0;
          sdo_en_d = 1'b1;
          sdo_d    = mo_q[31];
          mo_d     = {mo_q[30:0], 1'b0};
          bcnt_d   = 16'd7;
          div_d    = '0;
          sck_d    = 1'b0;
        end else if (!tick) begin
          div_d = div_q + DVW'(1);
        end else if (!sck_q) begin
          div_d = '0;
          sck_d = 1'b1;
          if (st_q == DATA) asm_d = {asm_q[DW-2:0], spi_sdi_i};
        end else begin
          div_d  = '0;
          sck_d  = 1'b0;
          bcnt_d = bcnt_q - 16'd1;
          if (st_q == CMD || st_q == ADDR) begin
            sdo_d = mo_q[31];
            mo_d  = {mo_q[30:0], 1'b0};
          end
          if (bcnt_q == '0) begin
            if (st_q == CMD) begin
              st_d   = ADDR;
              bcnt_d = 16'd23;
            end else if (st_q == ADDR) begin
              sdo_d    = 1'b0;
              sdo_en_d = 1'b0;
              st_d     = USE_DUMMY ? DUMMY : DATA;
              bcnt_d   = USE_DUMMY ? 16'(DUMMY_CYC - 1) : 16'(DW - 1);
            end else if (st_q == DUMMY) begin
              st_d   = DATA;
              bcnt_d = 16'(DW - 1);
            end else if (free) begin
              ld = 1'b1;
            end else begin
              st_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        div_d = '0;
        if (dout_ready) ld = 1'b1;
      end
      GAP: begin
        csn_d    = 1'b1;
        busy_d   = 1'b0;
        sck_d    = 1'b0;
        sdo_d    = 1'b0;
        sdo_en_d = 1'b0;
        if (gap_q == '0) begin
          st_d        = IDLE;
          req_ready_d = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
    endcase
    // csn stays low one more cycle so it rises just after the last word appears
    if (ld) begin
      dv_d   = 1'b1;
      dd_d   = asm_q;
      dl_d   = lst;
      div_d  = '0;
      bcnt_d = 16'(DW - 1);
      if (lst) begin
        st_d  = GAP;
        gap_d = GW'(CS_GAP);
      end else begin
        st_d   = DATA;
        wcnt_d = wcnt_q + 9'd1;
      end
    end
  end

  always_ff @(posedge spi_flash_aclk) begin
    if (spi_flash_areset) begin
      st_q        <= GAP;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      csn_q       <= 1'b1;
      sck_q       <= 1'b0;
      sdo_q       <= 1'b0;
      sdo_en_q    <= 1'b0;
      mo_q        <= '0;
      asm_q       <= '0;
      dd_q        <= '0;
      dv_q        <= 1'b0;
      dl_q        <= 1'b0;
      div_q       <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      len_q       <= '0;
      gap_q       <= GW'(CS_GAP - 1);
    end else begin
      st_q        <= st_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      csn_q       <= csn_d;
      sck_q       <= sck_d;
      sdo_q       <= sdo_d;
      sdo_en_q    <= sdo_en_d;
      mo_q        <= mo_d;
      asm_q       <= asm_d;
      dd_q        <= dd_d;
      dv_q        <= dv_d;
      dl_q        <= dl_d;
      div_q       <= div_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign spi_csn_o  = csn_q;
  assign spi_sck    = sck_q;
  assign spi_sdo_o  = sdo_q;
  assign spi_sdo_en = sdo_en_q;
  assign dout_valid = dv_q;
  assign dout_data  = dd_q;
  assign dout_last  = dl_q;

endmodule
